// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that lets N_REQ sprite requesters share one synchronous ROM.
// A grant registers the address and a one-hot tag; the tag reaches rsp_valid two cycles later.
module sprite_rom_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req_valid,
    input  logic [N_REQ*AW-1:0]   req_addr,
    output logic [N_REQ-1:0]      req_ready,
    output logic [AW-1:0]         rom_addr,
    input  logic [DW-1:0]         rom_data,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [DW-1:0]         rsp_data,
    output logic [15:0]           conflict_cnt
);

    localparam int unsigned IW = $clog2(N_REQ);

    logic [IW-1:0]    last_grant;
    logic [IW-1:0]    winner;
    logic [IW-1:0]    cand;
    logic             found;
    logic             handshake;
    logic             contended;
    logic [N_REQ-1:0] tag1;
    logic [N_REQ-1:0] tag2;
    int unsigned      idx;
    int unsigned      active;

    // Search starts one past the previous winner and wraps, giving round-robin fairness.
    always_comb begin
        found     = 1'b0;
        winner    = last_grant;
        cand      = '0;
        idx       = 0;
        req_ready = '0;
        for (int unsigned k = 1; k <= N_REQ; k++) begin
            idx  = (32'(last_grant) + k) % N_REQ;
            cand = IW'(idx);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
        handshake = found && !rst;
        if (handshake) begin
            req_ready[winner] = 1'b1;
        end
    end

    always_comb begin
        active = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            active = active + 32'(req_valid[k]);
        end
        contended = (active >= 2);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant   <= IW'(N_REQ - 1);
            rom_addr     <= '0;
            tag1         <= '0;
            tag2         <= '0;
            conflict_cnt <= '0;
        end else begin
            tag1 <= req_ready;
            tag2 <= tag1;
            if (handshake) begin
                last_grant <= winner;
                rom_addr   <= req_addr[32'(winner)*AW +: AW];
            end
            if (contended && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 16'd1;
            end
        end
    end

    assign rsp_valid = tag2;
    assign rsp_data  = rom_data;

endmodule
